cam_table: RTL

//  Parametrised content-addressable table, successor of the fixed 32x8 CAM.

---
 rtl/cam_table_pkg.sv | 16 +
 rtl/cam_table_penc.sv | 22 ++
 rtl/cam_table.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cam_table_pkg.sv
// Shared types for the cam_table block: request opcodes and controller states.
package cam_table_pkg;

    typedef enum logic [1:0] {
        CAM_OP_SEARCH = 2'd0,
        CAM_OP_INSERT = 2'd1,
        CAM_OP_DELETE = 2'd2,
        CAM_OP_FLUSH  = 2'd3
    } cam_op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } cam_state_e;

endpackage

// File: rtl/cam_table_penc.sv
// Lowest-index priority encoder: reports whether any bit is set and the index of the lowest one.
module cam_table_penc
    import cam_table_pkg::*;
#(
    parameter int N     = 32,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Scan high-to-low so the lowest set bit is the last to claim idx.
    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/cam_table.sv
// Parametrised CAM with SEARCH/INSERT/DELETE/FLUSH and a registered response per request.
// Optional ternary matching is enabled by defining CAM_TABLE_MASK_EN.
module cam_table
    import cam_table_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_key,
`ifdef CAM_TABLE_MASK_EN
    input  logic [DATA_W-1:0] req_mask,
`endif
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic              rsp_full,
    output logic [IDX_W:0]    count
);

    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] key_r [DEPTH];
`ifdef CAM_TABLE_MASK_EN
    logic [DATA_W-1:0] mask_r [DEPTH];
`endif
    logic [DEPTH-1:0]  valid_r;
    cam_state_e        state_r, state_nxt_s;
    logic [IDX_W-1:0]  flush_idx_r;
    logic [IDX_W:0]    count_r, count_nxt_s;
    logic              ready_r, rsp_valid_r, rsp_hit_r, rsp_full_r;
    logic [IDX_W-1:0]  rsp_idx_r;

    cam_op_e           op_s;
    logic              accept_s;
    logic [DEPTH-1:0]  look_vec_s;
    logic              hit_any_s, free_any_s;
    logic [IDX_W-1:0]  hit_idx_s, free_idx_s;
    logic              rsp_load_s, hit_nxt_s, full_nxt_s;
    logic [IDX_W-1:0]  idx_nxt_s, clr_idx_s;
    logic              set_en_s, clr_en_s;

    assign op_s     = cam_op_e'(req_op);
    assign accept_s = req_valid && ready_r;

    // INSERT dedups on stored-key (and mask) equality; other ops use the match rule.
    always_comb begin
        look_vec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_TABLE_MASK_EN
            if (op_s == CAM_OP_INSERT) begin
                look_vec_s[i] = valid_r[i] && (key_r[i] == req_key) && (mask_r[i] == req_mask);
            end else begin
                look_vec_s[i] = valid_r[i] && (((key_r[i] ^ req_key) & mask_r[i]) == '0);
            end
`else
            look_vec_s[i] = valid_r[i] && (key_r[i] == req_key);
`endif
        end
    end

    cam_table_penc #(.N(DEPTH), .IDX_W(IDX_W)) u_match_penc (
        .vec (look_vec_s),
        .any (hit_any_s),
        .idx (hit_idx_s)
    );

    cam_table_penc #(.N(DEPTH), .IDX_W(IDX_W)) u_free_penc (
        .vec (~valid_r),
        .any (free_any_s),
        .idx (free_idx_s)
    );

    // Next-state, table-update strobes and response contents.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        rsp_load_s  = 1'b0;
        hit_nxt_s   = 1'b0;
        full_nxt_s  = 1'b0;
        idx_nxt_s   = '0;
        set_en_s    = 1'b0;
        clr_en_s    = 1'b0;
        clr_idx_s   = hit_idx_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    rsp_load_s = 1'b1;
                    case (op_s)
                        CAM_OP_SEARCH: begin
                            hit_nxt_s = hit_any_s;
                            idx_nxt_s = hit_idx_s;
                        end
                        CAM_OP_INSERT: begin
                            if (hit_any_s) begin
                                hit_nxt_s = 1'b1;
                                idx_nxt_s = hit_idx_s;
                            end else if (free_any_s) begin
                                set_en_s    = 1'b1;
                                idx_nxt_s   = free_idx_s;
                                count_nxt_s = count_r + CNT_ONE;
                            end else begin
                                full_nxt_s = 1'b1;
                            end
                        end
                        CAM_OP_DELETE: begin
                            if (hit_any_s) begin
                                clr_en_s    = 1'b1;
                                hit_nxt_s   = 1'b1;
                                idx_nxt_s   = hit_idx_s;
                                count_nxt_s = count_r - CNT_ONE;
                            end else begin
                                hit_nxt_s = 1'b0;
                            end
                        end
                        CAM_OP_FLUSH: begin
                            rsp_load_s  = 1'b0;
                            state_nxt_s = ST_FLUSH;
                        end
                        default: begin
                            rsp_load_s = 1'b0;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                clr_en_s  = 1'b1;
                clr_idx_s = flush_idx_r;
                if (valid_r[flush_idx_r]) begin
                    count_nxt_s = count_r - CNT_ONE;
                end else begin
                    count_nxt_s = count_r;
                end
                if (flush_idx_r == LAST_IDX) begin
                    state_nxt_s = ST_IDLE;
                    rsp_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state, flush cursor, ready and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flush_idx_r <= '0;
            ready_r     <= 1'b1;
            count_r     <= '0;
        end else begin
            state_r     <= state_nxt_s;
            ready_r     <= (state_nxt_s == ST_IDLE);
            count_r     <= count_nxt_s;
            if (state_r == ST_FLUSH && flush_idx_r != LAST_IDX) begin
                flush_idx_r <= flush_idx_r + IDX_W'(1);
            end else begin
                flush_idx_r <= '0;
            end
        end
    end

    // Per-entry valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if (set_en_s) begin
            valid_r[free_idx_s] <= 1'b1;
        end else if (clr_en_s) begin
            valid_r[clr_idx_s] <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Key storage is deliberately left unreset; valid bits gate every match.
    always_ff @(posedge clk) begin
        if (set_en_s) begin
            key_r[free_idx_s]  <= req_key;
`ifdef CAM_TABLE_MASK_EN
            mask_r[free_idx_s] <= req_mask;
`endif
        end
    end

    // Response registers; payload holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_idx_r   <= '0;
            rsp_full_r  <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_load_s;
            if (rsp_load_s) begin
                rsp_hit_r  <= hit_nxt_s;
                rsp_idx_r  <= idx_nxt_s;
                rsp_full_r <= full_nxt_s;
            end
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_hit   = rsp_hit_r;
    assign rsp_idx   = rsp_idx_r;
    assign rsp_full  = rsp_full_r;
    assign count     = count_r;

endmodule
